tlu_stream_arb: RTL
===================

# tlu_stream_arb

Round-robin arbiter that shares the single stream_fifo input port between several 16-bit first-word-fall-through (FWFT) data sources. Sources include the tlu_master trigger/TDC stream and future status or timestamp producers. It sits between the sources and stream_fifo in the BUS_CLK domain and grants one source at a time with a bounded burst length. Each source therefore gets fair access to SRAM/USB bandwidth.

## Interface
- N_SRC, 4, number of sources (2..8)
- MAX_BURST, 64, max words popped per grant (1..255)
- BUS_CLK  in  1  clock; all inputs are synchronous to it
- BUS_RST_N  in  1  reset, asynchronous assert, active-low
- SRC_EN  in  N_SRC  per-source enable mask
- SRC_EMPTY  in  N_SRC  source i empty (FWFT)
- SRC_DATA  in  16*N_SRC  source i word on [16i+15:16i], valid while SRC_EMPTY[i]=0
- SRC_READ  out  N_SRC  pop strobe to source i
- FIFO_READ  in  1  pop request from stream_fifo (FIFO_READ_NEXT_OUT)
- FIFO_EMPTY  out  1  to stream_fifo FIFO_EMPTY_IN
- FIFO_DATA  out  16  to stream_fifo FIFO_DATA
- GRANT_ID  out  3  index of the granted source; 0 when idle
- BUSY  out  1  high while the FSM is not in IDLE
- WORD_CNT  out  32  total source words forwarded, wraps at 2^32

## Operation
- States: IDLE, HDR (only when STREAM_ARB_HEADER_EN is defined), GRANT.
- **IDLE**
  - FIFO_EMPTY=1 and SRC_READ=0.
  - Candidate set: SRC_EN[i] & !SRC_EMPTY[i].
  - Search starts at (LAST+1) mod N_SRC and wraps over N_SRC, including non-power-of-2 values.
  - First candidate found → G. Next state is HDR if the header is enabled, else GRANT. Burst counter is cleared.
- **HDR**
  - FIFO_EMPTY=0 and FIFO_DATA=16'hFF00|G.
  - On FIFO_READ → GRANT. No source pop occurs.
- **GRANT**
  - FIFO_EMPTY = SRC_EMPTY[G] | !SRC_EN[G].
  - FIFO_DATA = SRC_DATA[G], combinational passthrough.
  - SRC_READ[G] = FIFO_READ & !FIFO_EMPTY. All other SRC_READ bits stay 0.
  - Each pop increments the burst counter and WORD_CNT.
- **Exit GRANT → IDLE, LAST←G** on the first cycle where any of these holds:
  - a pop brings the burst counter to MAX_BURST (exit after that pop);
  - FIFO_EMPTY=1, i.e. the source drained or SRC_EN[G] dropped.
- FIFO_READ while FIFO_EMPTY=1 is ignored: no pop and no count.
- A burst of zero words is legal when a source drains during HDR.
- Reset values: SRC_READ=0, FIFO_EMPTY=1, FIFO_DATA=0, GRANT_ID=0, BUSY=0, WORD_CNT=0, LAST=N_SRC-1 (so source 0 wins first), state IDLE.
- Reset mid-burst aborts immediately. Outputs take their reset values asynchronously. Words already popped are not replayed.

## Timing
- Source goes non-empty at edge t (IDLE):
  - FIFO_EMPTY falls after edge t+1, presenting data (or the header);
  - first pop can occur at edge t+2.
- One bubble cycle is spent in IDLE between consecutive grants, even when the same source re-wins.
- Data path latency is zero within a grant: SRC_DATA[G] → FIFO_DATA is combinational.
- Sustained throughput is one word per cycle. Bus efficiency is MAX_BURST/(MAX_BURST+1) without the header and MAX_BURST/(MAX_BURST+2) with it.
- Outputs registered: GRANT_ID, BUSY, WORD_CNT.
- A pop at edge k is counted in WORD_CNT after edge k.
- SRC_EN changes take effect on the next arbitration decision, or immediately for the current grant via FIFO_EMPTY.

## Configuration
- STREAM_ARB_HEADER_EN
  - **Defined:** HDR state is present, and every grant is preceded by one header word 16'hFF00|G. Sources must never emit words with bits [15:8]=8'hFF.
  - **Undefined:** no HDR state; IDLE goes directly to GRANT; the stream is raw source data.

## Test plan
- Single source 0, 10 words queued, FIFO_READ held high, no header → 10 pops on consecutive cycles; FIFO_EMPTY falls 1 cycle after SRC_EMPTY[0] falls; WORD_CNT=10; return to IDLE.
- N_SRC=4, all sources full, MAX_BURST=4, FIFO_READ held high → grant order 0,1,2,3,0; exactly 4 words per grant; 1 bubble between grants.
- SRC_EN=4'b1010, all sources full → only sources 1 and 3 are ever granted; SRC_READ[0] and SRC_READ[2] stay 0.
- Source 2 drains after 3 words with MAX_BURST=64 → leaves GRANT the cycle SRC_EMPTY[2] rises; the next winner is 3 (wrap continues from LAST=2).
- STREAM_ARB_HEADER_EN defined, source 1 has 2 words → output stream 16'hFF01, d0, d1; SRC_READ[1] is not asserted on the header pop.
- BUS_RST_N pulsed low mid-burst on source 3 → FIFO_EMPTY=1 and SRC_READ=0 asynchronously; WORD_CNT=0; after release source 0 wins first.

Source files
------------

// File: rtl/tlu_stream_arb_if.sv
// rtl/tlu_stream_arb_if.sv - handshake bundle between FWFT sources, the arbiter and stream_fifo
interface tlu_stream_arb_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0]    SRC_EN;
  logic [N_SRC-1:0]    SRC_EMPTY;
  logic [16*N_SRC-1:0] SRC_DATA;
  logic [N_SRC-1:0]    SRC_READ;
  logic                FIFO_READ;
  logic                FIFO_EMPTY;
  logic [15:0]         FIFO_DATA;

  // master is the arbiter side; slave is the sources plus stream_fifo side
  modport master (
    input  SRC_EN, SRC_EMPTY, SRC_DATA, FIFO_READ,
    output SRC_READ, FIFO_EMPTY, FIFO_DATA
  );
  modport slave (
    output SRC_EN, SRC_EMPTY, SRC_DATA, FIFO_READ,
    input  SRC_READ, FIFO_EMPTY, FIFO_DATA
  );
endinterface

// File: rtl/tlu_stream_arb.sv
// rtl/tlu_stream_arb.sv - round-robin bounded-burst arbiter of FWFT sources onto stream_fifo
// Optional per-grant header word (16'hFF00|G) is built when STREAM_ARB_HEADER_EN is defined.
module tlu_stream_arb #(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 64
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST_N,
  tlu_stream_arb_if.master bus,
  output logic [2:0]       GRANT_ID,
  output logic             BUSY,
  output logic [31:0]      WORD_CNT
);

`ifdef STREAM_ARB_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_GRANT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT} state_t;
`endif

  state_t             state;
  logic [2:0]         last;
  logic [7:0]         burst_cnt;
  logic [7:0]         en_pad;
  logic [7:0]         empty_pad;
  logic [7:0]         req_pad;
  logic [127:0]       data_pad;
  logic               found;
  logic [2:0]         next_g;
  logic [3:0]         probe;
  logic               g_empty;
  logic               pop;
  logic               burst_done;
  logic               fifo_empty;
  logic [15:0]        fifo_data;
  logic [N_SRC-1:0]   src_read;

  // Pad to 8 sources so the 3-bit grant index can address every vector directly;
  // padded slots read as disabled and empty.
  assign en_pad    = 8'(bus.SRC_EN);
  assign empty_pad = ~8'(~bus.SRC_EMPTY);
  assign req_pad   = en_pad & ~empty_pad;
  assign data_pad  = 128'(bus.SRC_DATA);

  always_comb begin
    found  = 1'b0;
    next_g = '0;
    probe  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      probe = 4'(last) + 4'(k);
      if (probe >= 4'(N_SRC)) probe = probe - 4'(N_SRC);
      if (!found && req_pad[probe[2:0]]) begin
        found  = 1'b1;
        next_g = probe[2:0];
      end
    end
  end

  assign g_empty    = empty_pad[GRANT_ID] | ~en_pad[GRANT_ID];
  assign pop        = (state == S_GRANT) && bus.FIFO_READ && !g_empty;
  assign burst_done = pop && (burst_cnt == 8'(MAX_BURST - 1));

  always_comb begin
    fifo_empty = 1'b1;
    fifo_data  = '0;
    case (state)
`ifdef STREAM_ARB_HEADER_EN
      S_HDR: begin
        fifo_empty = 1'b0;
        fifo_data  = 16'hFF00 | {13'd0, GRANT_ID};
      end
`endif
      S_GRANT: begin
        fifo_empty = g_empty;
        fifo_data  = data_pad[{GRANT_ID, 4'b0000} +: 16];
      end
      default: ;
    endcase
  end

  always_comb begin
    src_read = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_read[i] = pop && (GRANT_ID == 3'(i));
    end
  end

  assign bus.FIFO_EMPTY = fifo_empty;
  assign bus.FIFO_DATA  = fifo_data;
  assign bus.SRC_READ   = src_read;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= S_IDLE;
      last      <= 3'(N_SRC - 1);
      burst_cnt <= '0;
      GRANT_ID  <= '0;
      BUSY      <= 1'b0;
      WORD_CNT  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            GRANT_ID  <= next_g;
            BUSY      <= 1'b1;
            burst_cnt <= '0;
`ifdef STREAM_ARB_HEADER_EN
            state     <= S_HDR;
`else
            state     <= S_GRANT;
`endif
          end
        end
`ifdef STREAM_ARB_HEADER_EN
        S_HDR: begin
          if (bus.FIFO_READ) state <= S_GRANT;
        end
`endif
        S_GRANT: begin
          if (pop) begin
            WORD_CNT  <= WORD_CNT + 32'd1;
            burst_cnt <= burst_cnt + 8'd1;
          end
          // Drained/disabled source or full burst both hand the bus back via IDLE
          if (g_empty || burst_done) begin
            state    <= S_IDLE;
            last     <= GRANT_ID;
            GRANT_ID <= '0;
            BUSY     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
